uart_dds_cmd_ctrl: RTL and testbench
====================================

Name: uart_dds_cmd_ctrl

Overview:
Parametrised multi-channel successor to the single-channel UART DDS controller. Parses framed command bytes from the UART receiver: header, channel index, 9 payload bytes, XOR checksum. Updates per-channel DDS control registers (wave, frequency, phase, amplitude) and returns an ACK/NAK byte to the UART transmitter. Sits between uart_rx/uart_tx and a bank of CH_NUM DDS cores.

Parameters:
CH_NUM, 4, number of DDS channels (1..254)
FREQ_W, 26, freq_ctrl width per channel (≤32)
PHASE_W, 9, phase_ctrl width per channel (≤16)
AMP_W, 14, amp_ctrl width per channel (≤16)
HEADER, 8'h41, frame start byte
TIMEOUT_CYC, 52083, idle clocks between frame bytes before abort (≈10 bit times at 9600 Bd, 50 MHz)
FREQ_RST / PHASE_RST / AMP_RST, 1000 / 90 / 8192, per-channel reset values

Ports:
sys_clk_50M  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
rx_data  in  8  byte from uart_rx (po_data)
rx_valid  in  1  one-cycle byte strobe (po_flag)
tx_data  out  8  response byte to uart_tx
tx_valid  out  1  response valid; held until tx_ready
tx_ready  in  1  transmitter accepts tx_data when tx_valid&tx_ready
wav_select  out  2*CH_NUM  channel k at [2k+1:2k]
freq_ctrl  out  FREQ_W*CH_NUM  channel k slice k
phase_ctrl  out  PHASE_W*CH_NUM  channel k slice k
amp_ctrl  out  AMP_W*CH_NUM  channel k slice k
load_done  out  CH_NUM  one-cycle pulse per channel updated
busy  out  1  high in any state except IDLE
err_cnt  out  8  saturating count of rejected/aborted frames

Behaviour:
- Reset (rst high at edge): state IDLE; all wav_select 0, freq FREQ_RST, phase PHASE_RST, amp AMP_RST; load_done 0, tx_valid 0, tx_data 0, err_cnt 0, byte index 0, checksum acc 0, timeout counter 0. Reset mid-frame or mid-response drops everything; no response is sent.
- Bytes are consumed only on rx_valid=1; rx_data is ignored otherwise.
- States: IDLE, CHAN, PAYLOAD, CSUM, LOAD, RESP.
- IDLE: rx_valid & rx_data==HEADER -> CHAN. Other bytes are discarded.
- CHAN: byte latched as channel id and loaded into checksum acc -> PAYLOAD, index 0.
- PAYLOAD: 9 bytes stored in buffer[0..8] and XORed into acc. After byte index 8 -> CSUM.
- Payload map (little-endian): b0[1:0]=wave; {b4,b3,b2,b1}=freq, truncated to FREQ_W LSBs; {b6,b5}=phase, truncated to PHASE_W; {b8,b7}=amp, truncated to AMP_W.
- CSUM: received byte compared with acc. Verdict is registered -> LOAD.
  - Good = checksum match and (chan < CH_NUM or chan==8'hFF).
- LOAD, one cycle:
  - If good: target channel registers are written and load_done[chan] pulses. Channel 8'hFF broadcasts to all channels and pulses all load_done bits.
  - If bad: no register changes, err_cnt++ (saturates at 255).
  - In both cases tx_data=8'h06 (good) or 8'h15 (bad) and tx_valid=1; -> RESP.
  - Latency: checksum byte sampled at edge E; outputs, load_done and tx_valid all change at edge E+1.
- RESP: tx_valid/tx_data held stable until tx_ready=1 at an edge. Then tx_valid=0 -> IDLE. rx_valid bytes in LOAD/RESP are dropped; a header arriving then is not captured.
- Timeout: the counter clears on every accepted byte and increments each cycle in CHAN/PAYLOAD/CSUM. When it reaches TIMEOUT_CYC-1: -> IDLE, err_cnt++, buffer discarded, no response.
- Simultaneous timeout terminal count and rx_valid: the byte wins and the counter clears.
- A HEADER-valued byte inside a frame is treated as data (no resync).

Test Plan:
- Reset: rst high 2 cycles -> every channel freq=1000, phase=90, amp=8192, wav=0; tx_valid=0, busy=0, err_cnt=0.
- Good frame 41 01 02 40 42 0F 00 B4 00 00 10 AA, tx_ready=1 -> ch1 wav=2, freq=1000000, phase=180, amp=4096; load_done=4'b0010 for one cycle at E+1; tx_data=06. Other channels unchanged.
- Same frame with checksum AB -> no register change, load_done=0, tx_data=15, err_cnt=1.
- Broadcast: channel FF, payload 01 E8 03 00 00 5A 00 00 20, checksum = XOR of all ten bytes -> all 4 channels wav=1, freq=1000, phase=90, amp=8192 (0x2000); load_done=4'b1111; ACK 06.
- Channel 05 with CH_NUM=4 and valid checksum -> NAK 15, err_cnt++. Separately, a frame stopping after 5 payload bytes -> IDLE after TIMEOUT_CYC, err_cnt++, tx_valid stays 0, no load_done.
- Hold tx_ready=0 for 100 cycles after a good frame and send a new header meanwhile -> tx_valid/tx_data stable, header ignored. After tx_ready=1 -> IDLE, busy=0; assert rst mid-frame -> IDLE with reset values.

Source files
------------

// File: rtl/uart_dds_cmd_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | uart_dds_cmd_ctrl : framed UART command parser for a bank of DDS channels |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module uart_dds_cmd_ctrl #(
   parameter int         CH_NUM      = 4,
   parameter int         FREQ_W      = 26,
   parameter int         PHASE_W     = 9,
   parameter int         AMP_W       = 14,
   parameter logic [7:0] HEADER      = 8'h41,
   parameter int         TIMEOUT_CYC = 52083,
   parameter int         FREQ_RST    = 1000,
   parameter int         PHASE_RST   = 90,
   parameter int         AMP_RST     = 8192
) (
   input  logic                      sys_clk_50M,
   input  logic                      rst,
   input  logic [7:0]                rx_data,
   input  logic                      rx_valid,
   output logic [7:0]                tx_data,
   output logic                      tx_valid,
   input  logic                      tx_ready,
   output logic [2*CH_NUM-1:0]       wav_select,
   output logic [FREQ_W*CH_NUM-1:0]  freq_ctrl,
   output logic [PHASE_W*CH_NUM-1:0] phase_ctrl,
   output logic [AMP_W*CH_NUM-1:0]   amp_ctrl,
   output logic [CH_NUM-1:0]         load_done,
   output logic                      busy,
   output logic [7:0]                err_cnt
);
   localparam int                 c_TMO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYC - 1);
   localparam logic [8:0]         c_CH_LIM   = 9'(CH_NUM);
   localparam logic [7:0]         c_ACK      = 8'h06;
   localparam logic [7:0]         c_NAK      = 8'h15;
   localparam logic [7:0]         c_BCAST    = 8'hFF;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CHAN    = 3'd1,
      S_PAYLOAD = 3'd2,
      S_CSUM    = 3'd3,
      S_LOAD    = 3'd4,
      S_RESP    = 3'd5
   } state_t;

   state_t               state_q, state_d;
   logic [3:0]           idx_q, idx_d;
   logic [7:0]           acc_q, acc_d;
   logic [7:0]           chan_q, chan_d;
   logic [7:0]           buf_q [9];
   logic [7:0]           buf_d [9];
   logic                 good_q, good_d;
   logic [c_TMO_W-1:0]   tmo_q, tmo_d;
   logic [7:0]           err_q, err_d;
   logic                 txv_q, txv_d;
   logic [7:0]           txd_q, txd_d;
   logic [CH_NUM-1:0]    ld_q, ld_d;
   logic [1:0]           wav_q   [CH_NUM];
   logic [1:0]           wav_d   [CH_NUM];
   logic [FREQ_W-1:0]    freq_q  [CH_NUM];
   logic [FREQ_W-1:0]    freq_d  [CH_NUM];
   logic [PHASE_W-1:0]   phase_q [CH_NUM];
   logic [PHASE_W-1:0]   phase_d [CH_NUM];
   logic [AMP_W-1:0]     amp_q   [CH_NUM];
   logic [AMP_W-1:0]     amp_d   [CH_NUM];

   logic [31:0]          w_freq_full;
   logic [15:0]          w_phase_full;
   logic [15:0]          w_amp_full;
   logic [7:0]           w_err_inc;
   logic                 w_unused;

   assign w_freq_full  = {buf_q[4], buf_q[3], buf_q[2], buf_q[1]};
   assign w_phase_full = {buf_q[6], buf_q[5]};
   assign w_amp_full   = {buf_q[8], buf_q[7]};
   assign w_err_inc    = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
   // Payload bits above the field widths are received but intentionally dropped.
   assign w_unused     = ^{buf_q[0][7:2], w_freq_full, w_phase_full, w_amp_full};

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      chan_d  = chan_q;
      buf_d   = buf_q;
      good_d  = good_q;
      tmo_d   = tmo_q;
      err_d   = err_q;
      txv_d   = txv_q;
      txd_d   = txd_q;
      ld_d    = '0;
      wav_d   = wav_q;
      freq_d  = freq_q;
      phase_d = phase_q;
      amp_d   = amp_q;

      case (state_q)
         S_IDLE: begin
            if (rx_valid && (rx_data == HEADER)) begin
               state_d = S_CHAN;
               tmo_d   = '0;
            end
         end
         S_CHAN: begin
            if (rx_valid) begin
               chan_d  = rx_data;
               acc_d   = rx_data;
               idx_d   = '0;
               state_d = S_PAYLOAD;
            end
         end
         S_PAYLOAD: begin
            if (rx_valid) begin
               buf_d[idx_q] = rx_data;
               acc_d        = acc_q ^ rx_data;
               idx_d        = idx_q + 4'd1;
               if (idx_q == 4'd8) state_d = S_CSUM;
            end
         end
         S_CSUM: begin
            if (rx_valid) begin
               good_d  = (rx_data == acc_q) &&
                         (({1'b0, chan_q} < c_CH_LIM) || (chan_q == c_BCAST));
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            for (int k = 0; k < CH_NUM; k++) begin
               if (good_q && ((chan_q == c_BCAST) || ({1'b0, chan_q} == 9'(k)))) begin
                  wav_d[k]   = buf_q[0][1:0];
                  freq_d[k]  = w_freq_full[FREQ_W-1:0];
                  phase_d[k] = w_phase_full[PHASE_W-1:0];
                  amp_d[k]   = w_amp_full[AMP_W-1:0];
                  ld_d[k]    = 1'b1;
               end
            end
            if (!good_q) err_d = w_err_inc;
            txv_d   = 1'b1;
            txd_d   = good_q ? c_ACK : c_NAK;
            state_d = S_RESP;
         end
         S_RESP: begin
            if (tx_ready) begin
               txv_d   = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Inter-byte watchdog; an arriving byte always beats the terminal count.
      if ((state_q == S_CHAN) || (state_q == S_PAYLOAD) || (state_q == S_CSUM)) begin
         if (rx_valid) begin
            tmo_d = '0;
         end else if (tmo_q == c_TMO_LAST) begin
            state_d = S_IDLE;
            tmo_d   = '0;
            idx_d   = '0;
            acc_d   = '0;
            err_d   = w_err_inc;
         end else begin
            tmo_d = tmo_q + c_TMO_W'(1);
         end
      end
   end

   always_ff @(posedge sys_clk_50M) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         acc_q   <= '0;
         chan_q  <= '0;
         good_q  <= 1'b0;
         tmo_q   <= '0;
         err_q   <= '0;
         txv_q   <= 1'b0;
         txd_q   <= '0;
         ld_q    <= '0;
         for (int i = 0; i < 9; i++) buf_q[i] <= '0;
         for (int k = 0; k < CH_NUM; k++) begin
            wav_q[k]   <= '0;
            freq_q[k]  <= FREQ_W'(FREQ_RST);
            phase_q[k] <= PHASE_W'(PHASE_RST);
            amp_q[k]   <= AMP_W'(AMP_RST);
         end
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
         chan_q  <= chan_d;
         good_q  <= good_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
         txv_q   <= txv_d;
         txd_q   <= txd_d;
         ld_q    <= ld_d;
         buf_q   <= buf_d;
         wav_q   <= wav_d;
         freq_q  <= freq_d;
         phase_q <= phase_d;
         amp_q   <= amp_d;
      end
   end

   for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
      assign wav_select[2*k +: 2]         = wav_q[k];
      assign freq_ctrl[FREQ_W*k +: FREQ_W] = freq_q[k];
      assign phase_ctrl[PHASE_W*k +: PHASE_W] = phase_q[k];
      assign amp_ctrl[AMP_W*k +: AMP_W]   = amp_q[k];
   end

   assign tx_data   = txd_q;
   assign tx_valid  = txv_q;
   assign load_done = ld_q;
   assign busy      = (state_q != S_IDLE);
   assign err_cnt   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_dds_cmd_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_uart_dds_cmd_ctrl : scoreboard bench with frame-level reference model  |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module tb_uart_dds_cmd_ctrl;
   localparam int CH  = 4;
   localparam int FW  = 26;
   localparam int PW  = 9;
   localparam int AW  = 14;
   localparam int TMO = 300;
   localparam logic [7:0] HDR = 8'h41;

   typedef struct packed {
      logic [7:0]       data;
      logic [7:0]       err;
      logic [2*CH-1:0]  wav;
      logic [FW*CH-1:0] freq;
      logic [PW*CH-1:0] phase;
      logic [AW*CH-1:0] amp;
   } snap_t;

   typedef struct packed {
      logic [CH-1:0] mask;
      snap_t         snap;
   } ld_exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [7:0]       rx_data = 8'h00;
   logic             rx_valid = 1'b0;
   logic             tx_ready = 1'b1;
   logic [7:0]       tx_data;
   logic             tx_valid;
   logic [2*CH-1:0]  wav_select;
   logic [FW*CH-1:0] freq_ctrl;
   logic [PW*CH-1:0] phase_ctrl;
   logic [AW*CH-1:0] amp_ctrl;
   logic [CH-1:0]    load_done;
   logic             busy;
   logic [7:0]       err_cnt;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int csum_cyc = 0;
   bit force_lo = 1'b0;
   bit rand_rdy = 1'b0;

   snap_t   tx_q [$];
   ld_exp_t ld_q [$];

   logic [1:0]    m_wav   [CH];
   logic [FW-1:0] m_freq  [CH];
   logic [PW-1:0] m_phase [CH];
   logic [AW-1:0] m_amp   [CH];
   logic [7:0]    m_err;

   uart_dds_cmd_ctrl #(
      .CH_NUM(CH), .FREQ_W(FW), .PHASE_W(PW), .AMP_W(AW),
      .HEADER(HDR), .TIMEOUT_CYC(TMO),
      .FREQ_RST(1000), .PHASE_RST(90), .AMP_RST(8192)
   ) dut (
      .sys_clk_50M(clk), .rst(rst),
      .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .wav_select(wav_select), .freq_ctrl(freq_ctrl),
      .phase_ctrl(phase_ctrl), .amp_ctrl(amp_ctrl),
      .load_done(load_done), .busy(busy), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic void m_reset();
      for (int k = 0; k < CH; k++) begin
         m_wav[k]   = 2'd0;
         m_freq[k]  = FW'(1000);
         m_phase[k] = PW'(90);
         m_amp[k]   = AW'(8192);
      end
      m_err = 8'd0;
   endfunction

   function automatic snap_t snapshot();
      snap_t s;
      s = '0;
      s.err = m_err;
      for (int k = 0; k < CH; k++) begin
         s.wav[2*k +: 2]    = m_wav[k];
         s.freq[FW*k +: FW] = m_freq[k];
         s.phase[PW*k +: PW] = m_phase[k];
         s.amp[AW*k +: AW]  = m_amp[k];
      end
      return s;
   endfunction

   function automatic logic [7:0] xsum(input logic [7:0] ch, input logic [71:0] pl);
      logic [7:0] x;
      x = ch;
      for (int i = 0; i < 9; i++) x = x ^ pl[8*i +: 8];
      return x;
   endfunction

   // Frame-level behaviour: checksum and channel validity decide, fields are little-endian numbers.
   function automatic bit model_frame(input logic [7:0] ch, input logic [71:0] pl, input logic [7:0] cs);
      bit     good;
      longint f, p, a;
      good = (cs == xsum(ch, pl)) && ((int'(ch) < CH) || (ch == 8'hFF));
      f = longint'(pl[15:8]) + longint'(pl[23:16]) * 256 + longint'(pl[31:24]) * 65536
          + longint'(pl[39:32]) * 16777216;
      p = longint'(pl[47:40]) + longint'(pl[55:48]) * 256;
      a = longint'(pl[63:56]) + longint'(pl[71:64]) * 256;
      if (good) begin
         for (int k = 0; k < CH; k++) begin
            if ((ch == 8'hFF) || (int'(ch) == k)) begin
               m_wav[k]   = 2'(int'(pl[7:0]) % 4);
               m_freq[k]  = FW'(f % (longint'(1) << FW));
               m_phase[k] = PW'(p % (longint'(1) << PW));
               m_amp[k]   = AW'(a % (longint'(1) << AW));
            end
         end
      end else if (m_err != 8'hFF) begin
         m_err = m_err + 8'd1;
      end
      return good;
   endfunction

   task automatic send_byte(input logic [7:0] b, input bit is_cs, input int gap);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      if (is_cs) csum_cyc = cyc;
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      repeat (gap) @(negedge clk);
   endtask

   task automatic wait_idle(input string nm, input int bound);
      int n;
      n = 0;
      while (busy && (n < bound)) begin
         @(negedge clk);
         n++;
      end
      chk(nm, busy, 1'b0);
   endtask

   // cs_mode: -1 correct checksum, -2 corrupted checksum, otherwise literal byte
   task automatic send_frame(input logic [7:0] ch, input logic [71:0] pl, input int cs_mode,
                             input bit wait_done);
      logic [7:0]    cs;
      logic [CH-1:0] mask;
      bit            good;
      snap_t         s;
      cs = xsum(ch, pl);
      if (cs_mode == -2) cs = cs ^ 8'(1 << $urandom_range(0, 7));
      else if (cs_mode >= 0) cs = 8'(cs_mode);
      good = model_frame(ch, pl, cs);
      s = snapshot();
      s.data = good ? 8'h06 : 8'h15;
      mask = (ch == 8'hFF) ? {CH{1'b1}} : CH'(1) << ch;
      if (good) ld_q.push_back({mask, s});
      tx_q.push_back(s);
      send_byte(HDR, 1'b0, $urandom_range(0, 2));
      send_byte(ch, 1'b0, $urandom_range(0, 2));
      for (int i = 0; i < 9; i++) send_byte(pl[8*i +: 8], 1'b0, $urandom_range(0, 2));
      send_byte(cs, 1'b1, 0);
      if (wait_done) wait_idle("frame_idle", 400);
   endtask

   task automatic chk_outs(input string tag);
      snap_t s;
      s = snapshot();
      chk({tag, "_wav"}, wav_select, s.wav);
      chk({tag, "_freq"}, freq_ctrl, s.freq);
      chk({tag, "_phase"}, phase_ctrl, s.phase);
      chk({tag, "_amp"}, amp_ctrl, s.amp);
      chk({tag, "_err"}, err_cnt, s.err);
   endtask

   // Monitor + tx_ready driver: ready is chosen first so a handshake decision uses the value seen at the next edge.
   initial begin : mon
      logic    r;
      logic    txv_prev;
      snap_t   te;
      ld_exp_t le;
      txv_prev = 1'b0;
      forever begin
         @(negedge clk);
         r = force_lo ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
         tx_ready = r;
         if (rst) begin
            txv_prev = 1'b0;
         end else begin
            if (load_done != '0) begin
               if (ld_q.size() == 0) begin
                  chk("unexpected_load", load_done, '0);
               end else begin
                  le = ld_q.pop_front();
                  chk("ld_mask", load_done, le.mask);
                  chk("ld_latency", cyc, csum_cyc + 2);
                  chk("ld_with_txv", tx_valid, 1'b1);
                  chk("ld_wav", wav_select, le.snap.wav);
                  chk("ld_freq", freq_ctrl, le.snap.freq);
                  chk("ld_phase", phase_ctrl, le.snap.phase);
                  chk("ld_amp", amp_ctrl, le.snap.amp);
               end
            end
            if (tx_valid && !txv_prev) chk("tx_latency", cyc, csum_cyc + 2);
            if (tx_valid) begin
               if (tx_q.size() == 0) begin
                  chk("unexpected_tx", tx_valid, 1'b0);
               end else begin
                  te = tx_q[0];
                  chk("tx_data", tx_data, te.data);
                  if (r) begin
                     void'(tx_q.pop_front());
                     chk("rsp_err", err_cnt, te.err);
                     chk("rsp_wav", wav_select, te.wav);
                     chk("rsp_freq", freq_ctrl, te.freq);
                     chk("rsp_phase", phase_ctrl, te.phase);
                     chk("rsp_amp", amp_ctrl, te.amp);
                  end
               end
            end
            txv_prev = tx_valid;
         end
      end
   end

   initial begin : watchdog
      #5ms;
      $display("FAIL watchdog: simulation did not finish, got running want done");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [71:0] pl;
      logic [7:0]  ch;
      int          r;
      m_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk_outs("reset");
      chk("reset_txv", tx_valid, 1'b0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_ld", load_done, '0);

      // Directed good frame to channel 1
      pl = {8'h10, 8'h00, 8'h00, 8'hB4, 8'h00, 8'h0F, 8'h42, 8'h40, 8'h02};
      send_frame(8'h01, pl, 8'hAA, 1'b1);
      chk("d_ch1_wav", wav_select[3:2], 2'd2);
      chk("d_ch1_freq", freq_ctrl[FW +: FW], 1000000);
      chk("d_ch1_phase", phase_ctrl[PW +: PW], 180);
      chk("d_ch1_amp", amp_ctrl[AW +: AW], 4096);
      chk("d_ch0_freq", freq_ctrl[0 +: FW], 1000);

      // Same frame, wrong checksum
      send_frame(8'h01, pl, 8'hAB, 1'b1);
      chk("d_bad_err", err_cnt, 8'd1);

      // Broadcast
      pl = {8'h20, 8'h00, 8'h00, 8'h5A, 8'h00, 8'h00, 8'h03, 8'hE8, 8'h01};
      send_frame(8'hFF, pl, -1, 1'b1);
      chk("d_bc_wav", wav_select, 8'h55);
      chk("d_bc_freq3", freq_ctrl[3*FW +: FW], 1000);
      chk("d_bc_amp2", amp_ctrl[2*AW +: AW], 14'h2000);

      // Out-of-range channel with a good checksum
      send_frame(8'h05, {9{8'h33}}, -1, 1'b1);
      chk("d_chan5_err", err_cnt, 8'd2);

      // Truncated frame: five payload bytes then silence
      send_byte(HDR, 1'b0, 0);
      send_byte(8'h02, 1'b0, 0);
      for (int i = 0; i < 5; i++) send_byte(8'(i + 7), 1'b0, 0);
      if (m_err != 8'hFF) m_err = m_err + 8'd1;
      repeat (TMO - 10) @(negedge clk);
      chk("tmo_still_busy", busy, 1'b1);
      wait_idle("tmo_idle", 40);
      chk("tmo_txv", tx_valid, 1'b0);
      chk_outs("tmo");

      // Response held off; a header arriving during the response must be dropped
      force_lo = 1'b1;
      send_frame(8'h03, {8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h03}, -1, 1'b0);
      repeat (50) @(negedge clk);
      send_byte(HDR, 1'b0, 0);
      repeat (50) @(negedge clk);
      chk("hold_txv", tx_valid, 1'b1);
      chk("hold_busy", busy, 1'b1);
      force_lo = 1'b0;
      wait_idle("hold_release", 20);
      repeat (3) @(negedge clk);
      chk("hold_header_dropped", busy, 1'b0);

      // Randomised frames with random back-pressure
      rand_rdy = 1'b1;
      for (int n = 0; n < 30; n++) begin
         r = $urandom_range(0, 9);
         if (r < 6) ch = 8'(r % CH);
         else if (r < 8) ch = 8'hFF;
         else ch = 8'($urandom_range(4, 254));
         pl = 72'({$urandom, $urandom, $urandom});
         send_frame(ch, pl, ($urandom_range(0, 4) == 0) ? -2 : -1, 1'b1);
      end
      rand_rdy = 1'b0;
      repeat (3) @(negedge clk);
      chk_outs("rand_end");

      // Reset in the middle of a frame
      send_byte(HDR, 1'b0, 0);
      send_byte(8'h00, 1'b0, 0);
      for (int i = 0; i < 3; i++) send_byte(8'hC3, 1'b0, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_reset();
      @(negedge clk);
      chk_outs("midrst");
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_txv", tx_valid, 1'b0);

      // A fresh frame after reset still parses
      send_frame(8'h02, {8'h3F, 8'hFF, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, -1, 1'b1);
      chk("post_ch2_freq", freq_ctrl[2*FW +: FW], 26'h3FFFFFF);
      chk("post_ch2_phase", phase_ctrl[2*PW +: PW], 9'h1FF);
      chk("post_ch2_amp", amp_ctrl[2*AW +: AW], 14'h3FFF);

      repeat (5) @(negedge clk);
      chk("txq_empty", tx_q.size(), 0);
      chk("ldq_empty", ld_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
